// File: rtl/id_scoreboard_regfile.sv
// ============================================================================
//  Module      : id_scoreboard_regfile
//  Description : Decode-stage register file with WB write-through bypass and
//                a per-register in-flight write scoreboard for RAW stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_scoreboard_regfile #(
    parameter  int XLEN         = 32,
    parameter  int NREGS        = 32,
    parameter  int MAX_INFLIGHT = 3,
    localparam int AW           = $clog2(NREGS),
    localparam int CW           = $clog2(MAX_INFLIGHT + 1),
    localparam int TW           = $clog2(NREGS * MAX_INFLIGHT + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic            rs1_used,
    input  logic            rs2_used,
    input  logic            issue,
    input  logic [AW-1:0]   issue_rd,
    input  logic            wb_load,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            kill,
    input  logic [AW-1:0]   kill_rd,
    output logic [XLEN-1:0] rs1_out,
    output logic [XLEN-1:0] rs2_out,
    output logic            stall,
    output logic [TW-1:0]   inflight,
    output logic            sb_err
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic [CW-1:0]   r_cnt  [NREGS];
    logic [TW-1:0]   r_inflight;
    logic            r_sb_err;

    logic            w_wb_hit1, w_wb_hit2;
    logic            w_busy1, w_busy2;
    logic            w_full;
    logic            w_accept;
    logic [CW:0]     w_sum      [NREGS];
    logic [CW-1:0]   w_cnt_next [NREGS];
    logic [TW-1:0]   w_total;
    logic            w_underflow;

    assign w_wb_hit1 = wb_load && (wb_rd == rs1);
    assign w_wb_hit2 = wb_load && (wb_rd == rs2);

    always_comb begin
        rs1_out = '0;
        rs2_out = '0;
        if (rs1 != '0) rs1_out = w_wb_hit1 ? wb_data : r_regs[rs1];
        if (rs2 != '0) rs2_out = w_wb_hit2 ? wb_data : r_regs[rs2];
    end

    // A last outstanding write landing this cycle is satisfied by the bypass.
    assign w_busy1 = (rs1 != '0) && (r_cnt[rs1] != '0)
                     && !((r_cnt[rs1] == CW'(1)) && w_wb_hit1);
    assign w_busy2 = (rs2 != '0) && (r_cnt[rs2] != '0)
                     && !((r_cnt[rs2] == CW'(1)) && w_wb_hit2);
    assign w_full  = issue && (issue_rd != '0)
                     && (r_cnt[issue_rd] == CW'(MAX_INFLIGHT));

    assign stall    = (rs1_used && w_busy1) || (rs2_used && w_busy2) || w_full;
    assign w_accept = issue && !stall;

    // Result lies in [-2, MAX_INFLIGHT], so the extra top bit acts as a sign.
    always_comb begin
        w_underflow = 1'b0;
        w_total     = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_sum[i]      = '0;
            w_cnt_next[i] = '0;
            if (i != 0) begin
                w_sum[i] = {1'b0, r_cnt[i]}
                         + (CW+1)'(w_accept && (issue_rd == AW'(i)))
                         - (CW+1)'(wb_load  && (wb_rd    == AW'(i)))
                         - (CW+1)'(kill     && (kill_rd  == AW'(i)));
                if (w_sum[i][CW]) w_underflow = 1'b1;
                else              w_cnt_next[i] = w_sum[i][CW-1:0];
            end
            w_total = w_total + TW'(w_cnt_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_inflight <= '0;
            r_sb_err   <= 1'b0;
        end else begin
            if (wb_load && (wb_rd != '0)) r_regs[wb_rd] <= wb_data;
            for (int i = 0; i < NREGS; i++) r_cnt[i] <= w_cnt_next[i];
            r_inflight <= w_total;
            r_sb_err   <= r_sb_err | w_underflow;
        end
    end

    assign inflight = r_inflight;
    assign sb_err   = r_sb_err;

endmodule

`default_nettype wire

// File: tb/tb_id_scoreboard_regfile.sv
// ============================================================================
//  Module      : tb_id_scoreboard_regfile
//  Description : Directed self-checking bench for id_scoreboard_regfile.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_scoreboard_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1, rs2, issue_rd, wb_rd, kill_rd;
    logic        rs1_used, rs2_used, issue, wb_load, kill;
    logic [31:0] wb_data;
    logic [31:0] rs1_out, rs2_out;
    logic        stall, sb_err;
    logic [6:0]  inflight;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_scoreboard_regfile #(.XLEN(32), .NREGS(32), .MAX_INFLIGHT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .issue(issue), .issue_rd(issue_rd),
        .wb_load(wb_load), .wb_rd(wb_rd), .wb_data(wb_data),
        .kill(kill), .kill_rd(kill_rd),
        .rs1_out(rs1_out), .rs2_out(rs2_out),
        .stall(stall), .inflight(inflight), .sb_err(sb_err)
    );

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic        wbl;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic [31:0] e1, e2;
    } vec_t;

    vec_t tv [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        rs1 = '0; rs2 = '0; rs1_used = 1'b0; rs2_used = 1'b0;
        issue = 1'b0; issue_rd = '0; wb_load = 1'b0; wb_rd = '0;
        wb_data = '0; kill = 1'b0; kill_rd = '0;
    endtask

    // Inputs change 1ns after the rising edge; checks happen at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        tv[0] = '{rs1:5,  rs2:10, wbl:0, wbrd:0,  wbd:32'h0,        e1:32'hDEADBEEF, e2:32'h12345678};
        tv[1] = '{rs1:0,  rs2:31, wbl:0, wbrd:0,  wbd:32'h0,        e1:32'h0,        e2:32'hA5A5A5A5};
        tv[2] = '{rs1:10, rs2:10, wbl:1, wbrd:10, wbd:32'hCAFEF00D, e1:32'hCAFEF00D, e2:32'hCAFEF00D};
        tv[3] = '{rs1:10, rs2:0,  wbl:0, wbrd:0,  wbd:32'h0,        e1:32'hCAFEF00D, e2:32'h0};
        tv[4] = '{rs1:0,  rs2:5,  wbl:1, wbrd:0,  wbd:32'hFFFFFFFF, e1:32'h0,        e2:32'hDEADBEEF};
        tv[5] = '{rs1:31, rs2:5,  wbl:1, wbrd:7,  wbd:32'h00001111, e1:32'hA5A5A5A5, e2:32'hDEADBEEF};
        tv[6] = '{rs1:7,  rs2:31, wbl:0, wbrd:0,  wbd:32'h0,        e1:32'h00001111, e2:32'hA5A5A5A5};
        tv[7] = '{rs1:5,  rs2:7,  wbl:1, wbrd:5,  wbd:32'h0BADC0DE, e1:32'h0BADC0DE, e2:32'h00001111};

        // Reset state
        rst_n = 1'b0;
        idle();
        rs1 = 5'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_sb_err", 32'(sb_err), 32'd0);
        chk("rst_rs1_out", rs1_out, 32'd0);
        #1 rst_n = 1'b1;

        // 1: same-cycle bypass, then stored value
        next_cycle();
        wb_load = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF; rs1 = 5'd5;
        @(negedge clk);
        chk("t1_bypass", rs1_out, 32'hDEADBEEF);
        next_cycle();
        idle(); rs1 = 5'd5;
        @(negedge clk);
        chk("t1_stored", rs1_out, 32'hDEADBEEF);
        chk("t1_sb_err_underflow", 32'(sb_err), 32'd1);
        chk("t1_inflight", 32'(inflight), 32'd0);
        next_cycle();
        wb_load = 1'b1; wb_rd = 5'd10; wb_data = 32'h12345678;
        next_cycle();
        wb_rd = 5'd31; wb_data = 32'hA5A5A5A5;
        next_cycle();
        idle();

        // Read-path vectors (no outstanding writes, so no stall)
        for (int i = 0; i < 8; i++) begin
            rs1 = tv[i].rs1; rs2 = tv[i].rs2; rs1_used = 1'b1; rs2_used = 1'b1;
            wb_load = tv[i].wbl; wb_rd = tv[i].wbrd; wb_data = tv[i].wbd;
            @(negedge clk);
            chk($sformatf("vec%0d_rs1", i), rs1_out, tv[i].e1);
            chk($sformatf("vec%0d_rs2", i), rs2_out, tv[i].e2);
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'd0);
            next_cycle();
        end
        idle();

        // 2: RAW stall until the writeback lands
        issue = 1'b1; issue_rd = 5'd7;
        @(negedge clk);
        chk("t2_issue_nostall", 32'(stall), 32'd0);
        next_cycle();
        idle(); rs2 = 5'd7; rs2_used = 1'b1;
        @(negedge clk);
        chk("t2_stall_a", 32'(stall), 32'd1);
        chk("t2_inflight", 32'(inflight), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("t2_stall_b", 32'(stall), 32'd1);
        next_cycle();
        wb_load = 1'b1; wb_rd = 5'd7; wb_data = 32'h00000077;
        @(negedge clk);
        chk("t2_wb_nostall", 32'(stall), 32'd0);
        chk("t2_wb_bypass", rs2_out, 32'h00000077);
        next_cycle();
        wb_load = 1'b0;
        @(negedge clk);
        chk("t2_after_stall", 32'(stall), 32'd0);
        chk("t2_after_inflight", 32'(inflight), 32'd0);
        next_cycle();
        idle();

        // 3: saturation at MAX_INFLIGHT
        issue = 1'b1; issue_rd = 5'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t3_issue%0d", k), 32'(stall), 32'd0);
            next_cycle();
        end
        @(negedge clk);
        chk("t3_full_stall", 32'(stall), 32'd1);
        chk("t3_inflight3", 32'(inflight), 32'd3);
        next_cycle();
        @(negedge clk);
        chk("t3_held_stall", 32'(stall), 32'd1);
        chk("t3_held_inflight", 32'(inflight), 32'd3);
        next_cycle();
        // Drain: only the last landing write is bypass-covered
        idle(); rs1 = 5'd3; rs1_used = 1'b1; wb_load = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
        @(negedge clk);
        chk("t3_drain3_stall", 32'(stall), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("t3_drain2_stall", 32'(stall), 32'd1);
        chk("t3_drain2_inflight", 32'(inflight), 32'd2);
        next_cycle();
        @(negedge clk);
        chk("t3_drain1_stall", 32'(stall), 32'd0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("t3_drained", 32'(inflight), 32'd0);
        next_cycle();

        // 4: issue and writeback to the same register net to zero
        issue = 1'b1; issue_rd = 5'd9;
        next_cycle();
        wb_load = 1'b1; wb_rd = 5'd9; wb_data = 32'h99;
        @(negedge clk);
        chk("t4_accept", 32'(stall), 32'd0);
        next_cycle();
        idle(); rs1 = 5'd9; rs1_used = 1'b1;
        @(negedge clk);
        chk("t4_inflight", 32'(inflight), 32'd1);
        chk("t4_still_busy", 32'(stall), 32'd1);
        next_cycle();
        wb_load = 1'b1; wb_rd = 5'd9; wb_data = 32'h9A;
        next_cycle();
        idle();
        @(negedge clk);
        chk("t4_drained", 32'(inflight), 32'd0);
        next_cycle();

        // 5: kill releases the outstanding write
        issue = 1'b1; issue_rd = 5'd4;
        next_cycle();
        idle(); rs1 = 5'd4; rs1_used = 1'b1;
        @(negedge clk);
        chk("t5_busy", 32'(stall), 32'd1);
        next_cycle();
        kill = 1'b1; kill_rd = 5'd4;
        next_cycle();
        kill = 1'b0;
        @(negedge clk);
        chk("t5_cleared", 32'(stall), 32'd0);
        chk("t5_inflight", 32'(inflight), 32'd0);
        next_cycle();

        // 6: reg0 writes, kill underflow, async reset mid-stall
        do_reset();
        wb_load = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
        next_cycle();
        idle();
        @(negedge clk);
        chk("t6_reg0_read", rs1_out, 32'd0);
        chk("t6_reg0_no_err", 32'(sb_err), 32'd0);
        next_cycle();
        kill = 1'b1; kill_rd = 5'd6;
        next_cycle();
        idle();
        @(negedge clk);
        chk("t6_kill_underflow", 32'(sb_err), 32'd1);
        next_cycle();
        issue = 1'b1; issue_rd = 5'd8;
        next_cycle();
        idle(); rs1 = 5'd8; rs1_used = 1'b1;
        #1;
        chk("t6_pre_rst_stall", 32'(stall), 32'd1);
        chk("t6_pre_rst_inflight", 32'(inflight), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_stall", 32'(stall), 32'd0);
        chk("t6_async_inflight", 32'(inflight), 32'd0);
        chk("t6_async_sb_err", 32'(sb_err), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        wb_load = 1'b1; wb_rd = 5'd8; wb_data = 32'h88;
        next_cycle();
        idle(); rs1 = 5'd8;
        @(negedge clk);
        chk("t6_late_wb_err", 32'(sb_err), 32'd1);
        chk("t6_late_wb_store", rs1_out, 32'h00000088);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
